// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/
// execute/memory/writeback with a variable-latency memory handshake.
// Ports:
//   clk, reset        : clock, async active-high reset
//   op                : opcode from IR[31:26], used in DECODE
//   mem_ready         : memory access completes this cycle
//   iord, memwrite    : memory address select, write strobe
//   irwrite, pcwrite  : IR load, unconditional PC load
//   branch, branch_ne : PC load on ALU zero / not zero
//   alusrca, alusrcb  : ALU operand selects
//   aluop, pcsrc      : ALU function, PC source
//   regdst, memtoreg  : write register / writeback data selects
//   regwrite          : register-file write enable
//   illegal_op        : pulse in DECODE on unsupported opcode
//   state             : current state (debug)
module multicycle_ctrl #(
   parameter int EN_BNE   = 1,
   parameter int EN_ORI   = 1,
   parameter int MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       branch,
   output logic       branch_ne,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam logic BNE_ON = (EN_BNE != 0);
   localparam logic ORI_ON = (EN_ORI != 0);
   localparam logic WAIT_ON = (MEM_WAIT != 0);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      IMMWB    = 4'd10,
      JUMP     = 4'd11,
      ORIEXEC  = 4'd12
   } state_t;

   state_t     cur;
   state_t     nxt;
   logic [5:0] op_q;
   logic       rdy;

   // Without the handshake every memory state is a single cycle.
   assign rdy   = mem_ready | ~WAIT_ON;
   assign state = cur;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur  <= FETCH;
         op_q <= '0;
      end else begin
         cur <= nxt;
         if (cur == DECODE) begin
            op_q <= op;
         end
      end
   end

   always_comb begin
      nxt        = FETCH;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      branch_ne  = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      illegal_op = 1'b0;
      case (cur)
         FETCH: begin
            alusrcb = 2'b01;
            irwrite = rdy;
            pcwrite = rdy;
            nxt     = rdy ? DECODE : FETCH;
         end
         DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW,
               OP_SW:   nxt = MEMADR;
               OP_R:    nxt = EXECUTE;
               OP_BEQ:  nxt = BRANCH;
               OP_ADDI: nxt = ADDIEXEC;
               OP_J:    nxt = JUMP;
               OP_BNE: begin
                  if (BNE_ON) nxt = BRANCH;
                  else illegal_op = 1'b1;
               end
               OP_ORI: begin
                  if (ORI_ON) nxt = ORIEXEC;
                  else illegal_op = 1'b1;
               end
               default: illegal_op = 1'b1;
            endcase
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            nxt     = (op_q == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            iord = 1'b1;
            nxt  = rdy ? MEMWB : MEMRD;
         end
         MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
            nxt      = rdy ? FETCH : MEMWR;
         end
         EXECUTE: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
            nxt     = ALUWB;
         end
         ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         BRANCH: begin
            alusrca   = 1'b1;
            aluop     = 2'b01;
            pcsrc     = 2'b01;
            branch    = (op_q == OP_BEQ);
            branch_ne = (op_q == OP_BNE);
         end
         ADDIEXEC: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            nxt     = IMMWB;
         end
         IMMWB: begin
            regwrite = 1'b1;
         end
         JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         ORIEXEC: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            aluop   = 2'b11;
            nxt     = IMMWB;
         end
         default: nxt = FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: vector table, corner sequences and a
// randomized run against an instruction-level reference model.
module tb_multicycle_ctrl;

   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] BNE  = 6'b000101;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] ORI  = 6'b001101;
   localparam logic [5:0] JMP  = 6'b000010;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [5:0] op1, op0;
   logic       mr1, mr0;

   logic       iord1, memwrite1, irwrite1, pcwrite1, branch1;
   logic       branch_ne1, alusrca1, regdst1, memtoreg1;
   logic       regwrite1, illegal_op1;
   logic [1:0] alusrcb1, aluop1, pcsrc1;
   logic [3:0] state1;

   logic       iord0, memwrite0, irwrite0, pcwrite0, branch0;
   logic       branch_ne0, alusrca0, regdst0, memtoreg0;
   logic       regwrite0, illegal_op0;
   logic [1:0] alusrcb0, aluop0, pcsrc0;
   logic [3:0] state0;

   multicycle_ctrl dut1 (
      .clk(clk), .reset(reset), .op(op1), .mem_ready(mr1),
      .iord(iord1), .memwrite(memwrite1), .irwrite(irwrite1),
      .pcwrite(pcwrite1), .branch(branch1), .branch_ne(branch_ne1),
      .alusrca(alusrca1), .alusrcb(alusrcb1), .aluop(aluop1),
      .pcsrc(pcsrc1), .regdst(regdst1), .memtoreg(memtoreg1),
      .regwrite(regwrite1), .illegal_op(illegal_op1),
      .state(state1)
   );

   multicycle_ctrl #(.EN_BNE(0), .EN_ORI(0), .MEM_WAIT(0)) dut0 (
      .clk(clk), .reset(reset), .op(op0), .mem_ready(mr0),
      .iord(iord0), .memwrite(memwrite0), .irwrite(irwrite0),
      .pcwrite(pcwrite0), .branch(branch0), .branch_ne(branch_ne0),
      .alusrca(alusrca0), .alusrcb(alusrcb0), .aluop(aluop0),
      .pcsrc(pcsrc0), .regdst(regdst0), .memtoreg(memtoreg0),
      .regwrite(regwrite0), .illegal_op(illegal_op0),
      .state(state0)
   );

   // {iord,memwrite,irwrite,pcwrite,branch,branch_ne,alusrca,
   //  alusrcb,aluop,pcsrc,regdst,memtoreg,regwrite,illegal_op,state}
   wire [20:0] o1 = {iord1, memwrite1, irwrite1, pcwrite1, branch1,
                     branch_ne1, alusrca1, alusrcb1, aluop1, pcsrc1,
                     regdst1, memtoreg1, regwrite1, illegal_op1,
                     state1};
   wire [20:0] o0 = {iord0, memwrite0, irwrite0, pcwrite0, branch0,
                     branch_ne0, alusrca0, alusrcb0, aluop0, pcsrc0,
                     regdst0, memtoreg0, regwrite0, illegal_op0,
                     state0};

   int vecs = 0;
   int bad  = 0;

   task automatic chk(input string nm, input logic [20:0] act,
                      input logic [20:0] exp);
      vecs++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   function automatic bit legal(input logic [5:0] o, input bit en);
      return (o inside {LW, SW, RT, BEQ, ADDI, JMP}) ||
             (en && (o == BNE || o == ORI));
   endfunction

   // Control word each state must present, straight from the
   // state/output table.
   function automatic logic [20:0] ref_out(input int s,
         input logic r, input logic [5:0] o, input bit en);
      logic iord_, mw_, ir_, pc_, br_, bn_, asa_, rd_, m2r_, rw_, il_;
      logic [1:0] asb_, aop_, psrc_;
      logic rdy;
      rdy = en ? r : 1'b1;
      {iord_, mw_, ir_, pc_, br_, bn_, asa_, rd_, m2r_, rw_, il_} = '0;
      {asb_, aop_, psrc_} = '0;
      case (s)
         0: begin asb_ = 2'b01; ir_ = rdy; pc_ = rdy; end
         1: begin asb_ = 2'b11; il_ = !legal(o, en); end
         2: begin asa_ = 1; asb_ = 2'b10; end
         3: iord_ = 1;
         4: begin rw_ = 1; m2r_ = 1; end
         5: begin iord_ = 1; mw_ = 1; end
         6: begin asa_ = 1; aop_ = 2'b10; end
         7: begin rd_ = 1; rw_ = 1; end
         8: begin
            asa_ = 1; aop_ = 2'b01; psrc_ = 2'b01;
            br_ = (o == BEQ); bn_ = (o == BNE);
         end
         9: begin asa_ = 1; asb_ = 2'b10; end
         10: rw_ = 1;
         11: begin psrc_ = 2'b10; pc_ = 1; end
         12: begin asa_ = 1; asb_ = 2'b10; aop_ = 2'b11; end
         default: ;
      endcase
      return {iord_, mw_, ir_, pc_, br_, bn_, asa_, asb_, aop_, psrc_,
              rd_, m2r_, rw_, il_, 4'(s)};
   endfunction

   // State walk of one instruction, ignoring memory stalls.
   int seq[$];
   function automatic void build(input logic [5:0] o, input bit en);
      if (o == LW)                 seq = '{0, 1, 2, 3, 4};
      else if (o == SW)            seq = '{0, 1, 2, 5};
      else if (o == RT)            seq = '{0, 1, 6, 7};
      else if (o == BEQ)           seq = '{0, 1, 8};
      else if (o == BNE && en)     seq = '{0, 1, 8};
      else if (o == ADDI)          seq = '{0, 1, 9, 10};
      else if (o == ORI && en)     seq = '{0, 1, 12, 10};
      else if (o == JMP)           seq = '{0, 1, 11};
      else                         seq = '{0, 1};
   endfunction

   task automatic drive(input bit sel, input logic [5:0] o,
                        input logic r);
      if (sel) begin op1 = o; mr1 = r; end
      else begin op0 = o; mr0 = r; end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic run_rand(input bit sel, input int n);
      pulse_reset();
      for (int i = 0; i < n; i++) begin
         logic [5:0] o;
         int idx;
         case ($urandom_range(0, 9))
            0: o = LW;   1: o = SW;   2: o = RT;   3: o = BEQ;
            4: o = BNE;  5: o = ADDI; 6: o = ORI;  7: o = JMP;
            default: o = 6'($urandom);
         endcase
         build(o, sel);
         idx = 0;
         while (idx < seq.size()) begin
            logic r;
            r = ($urandom_range(0, 3) != 0);
            drive(sel, o, r);
            #3;
            chk(sel ? "rand_w" : "rand_nw", sel ? o1 : o0,
                ref_out(seq[idx], r, o, sel));
            @(posedge clk); #1;
            if (!(sel && !r && (seq[idx] inside {0, 3, 5}))) idx++;
         end
      end
   endtask

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic       mr;
      logic [3:0] st;
      logic [3:0] we;   // {irwrite, pcwrite, memwrite, regwrite}
      logic [1:0] br;   // {branch, branch_ne}
      logic       ill;
   } vec_t;

   vec_t tv[$];

   function automatic void add(input logic rst, input logic [5:0] o,
         input logic mr, input logic [3:0] st, input logic [3:0] we,
         input logic [1:0] br, input logic ill);
      vec_t v;
      v.rst = rst; v.op = o; v.mr = mr; v.st = st;
      v.we = we; v.br = br; v.ill = ill;
      tv.push_back(v);
   endfunction

   initial begin
      reset = 1'b1;
      op1 = '0; op0 = '0; mr1 = 1'b1; mr0 = 1'b1;

      add(1, LW, 1, 0, 4'b1100, 0, 0);
      add(0, LW, 1, 0, 4'b1100, 0, 0);
      add(0, LW, 1, 1, 4'b0000, 0, 0);
      add(0, LW, 1, 2, 4'b0000, 0, 0);
      add(0, LW, 1, 3, 4'b0000, 0, 0);
      add(0, LW, 1, 4, 4'b0001, 0, 0);
      add(0, SW, 0, 0, 4'b0000, 0, 0);
      add(0, SW, 0, 0, 4'b0000, 0, 0);
      add(0, SW, 1, 0, 4'b1100, 0, 0);
      add(0, SW, 1, 1, 4'b0000, 0, 0);
      add(0, SW, 0, 2, 4'b0000, 0, 0);
      add(0, SW, 0, 5, 4'b0010, 0, 0);
      add(0, SW, 0, 5, 4'b0010, 0, 0);
      add(0, SW, 0, 5, 4'b0010, 0, 0);
      add(0, SW, 1, 5, 4'b0010, 0, 0);
      add(0, BNE, 1, 0, 4'b1100, 0, 0);
      add(0, BNE, 1, 1, 4'b0000, 0, 0);
      add(0, BNE, 1, 8, 4'b0000, 2'b01, 0);
      add(0, BEQ, 1, 0, 4'b1100, 0, 0);
      add(0, BEQ, 1, 1, 4'b0000, 0, 0);
      add(0, BEQ, 1, 8, 4'b0000, 2'b10, 0);
      add(0, ORI, 1, 0, 4'b1100, 0, 0);
      add(0, ORI, 1, 1, 4'b0000, 0, 0);
      add(0, ORI, 1, 12, 4'b0000, 0, 0);
      add(0, ORI, 1, 10, 4'b0001, 0, 0);
      add(0, 6'h3f, 1, 0, 4'b1100, 0, 0);
      add(0, 6'h3f, 1, 1, 4'b0000, 0, 1);
      add(0, 6'h3f, 0, 0, 4'b0000, 0, 0);

      @(posedge clk); #1;
      foreach (tv[i]) begin
         reset = tv[i].rst;
         op1   = tv[i].op;
         mr1   = tv[i].mr;
         #3;
         chk($sformatf("vec%0d", i),
             21'({state1, irwrite1, pcwrite1, memwrite1, regwrite1,
                  branch1, branch_ne1, illegal_op1}),
             21'({tv[i].st, tv[i].we, tv[i].br, tv[i].ill}));
         @(posedge clk); #1;
      end

      // Async reset while a store is stalled in MEMWR.
      op1 = SW; mr1 = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      mr1 = 1'b0;
      #3;
      chk("memwr_entered", 21'({state1, memwrite1}), 21'({4'd5, 1'b1}));
      reset = 1'b1;
      #1;
      chk("async_drop", 21'({state1, memwrite1, regwrite1}),
          21'({4'd0, 1'b0, 1'b0}));
      @(posedge clk); #1;
      reset = 1'b0;
      #3;
      chk("post_reset", 21'(state1), 21'd0);

      // Reduced build: BNE is illegal and FETCH ignores mem_ready.
      op0 = BNE; mr0 = 1'b0;
      #1;
      chk("nw_fetch", 21'({state0, irwrite0, pcwrite0}),
          21'({4'd0, 2'b11}));
      @(posedge clk); #4;
      chk("nw_bne_ill", 21'({state0, illegal_op0, branch_ne0}),
          21'({4'd1, 1'b1, 1'b0}));
      @(posedge clk); #4;
      chk("nw_back", 21'({state0, illegal_op0}), 21'({4'd0, 1'b0}));
      @(posedge clk); #1;

      run_rand(1'b1, 300);
      run_rand(1'b0, 300);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
      $finish;
   end

endmodule
